// File: rtl/frac_pixel_writer.sv
// Packs raster-order 16-bit pixels into 32-bit words, double-buffers them per burst
// and drains each full bank as one addressed write burst; flags frame end and ordering errors.
module frac_pixel_writer #(
  parameter int unsigned H_RES     = 640,
  parameter int unsigned V_RES     = 480,
  parameter int unsigned BURST_LEN = 4,
  parameter logic [21:0] FB_BASE   = 22'h000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pix_valid,
  output logic        pix_ready,
  input  logic [15:0] pix_data,
  input  logic [9:0]  pix_x,
  input  logic [8:0]  pix_y,
  output logic        wr_req,
  output logic [21:0] wr_addr,
  input  logic        wr_ack,
  output logic [31:0] wr_data,
  output logic        wr_data_valid,
  input  logic        wr_data_ready,
  output logic        frame_done,
  output logic        seq_err
);

  localparam int unsigned BW = $clog2(BURST_LEN);
  localparam int unsigned PW = BW + 1;
  localparam logic [9:0]    X_LAST    = 10'(H_RES - 1);
  localparam logic [8:0]    Y_LAST    = 9'(V_RES - 1);
  localparam logic [21:0]   H_RES_A   = 22'(H_RES);
  localparam logic [BW-1:0] BEAT_LAST = BW'(BURST_LEN - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DATA} state_e;

  // Fill side state
  logic [9:0]  ex_q, ex_d;
  logic [8:0]  ey_q, ey_d;
  logic        fill_bank_q, fill_bank_d;
  logic [1:0]  full_q, full_d;
  logic [1:0]  eof_q, eof_d;
  logic        seq_err_q, seq_err_d;
  logic [21:0] bank_addr_q [2];
  logic [31:0] mem_q [2][BURST_LEN];

  // Drain side state
  state_e      state_q, state_d;
  logic [BW-1:0] beat_q, beat_d;
  logic        drain_bank_q, drain_bank_d;
  logic        frame_done_q, frame_done_d;

  logic          accept;
  logic [PW-1:0] pos;
  logic [BW-1:0] wsel;
  logic          bank_first;
  logic          bank_last;
  logic          pix_last;
  logic [21:0]   pix_addr;
  logic          xfer;
  logic          burst_done;

  // Bank slot follows ex directly because a line is a whole number of banks.
  assign pos        = ex_q[PW-1:0];
  assign wsel       = pos[PW-1:1];
  assign bank_first = (pos == '0);
  assign bank_last  = (pos == '1);
  assign pix_last   = (ex_q == X_LAST) && (ey_q == Y_LAST);
  assign pix_addr   = FB_BASE + 22'(ey_q) * H_RES_A + 22'(ex_q);

  assign pix_ready  = !rst && !full_q[fill_bank_q];
  assign accept     = pix_valid && pix_ready;

  assign xfer       = (state_q == S_DATA) && wr_data_ready;
  assign burst_done = xfer && (beat_q == BEAT_LAST);

  always_comb begin
    ex_d        = ex_q;
    ey_d        = ey_q;
    fill_bank_d = fill_bank_q;
    eof_d       = eof_q;
    seq_err_d   = seq_err_q;
    if (accept) begin
      if ((pix_x != ex_q) || (pix_y != ey_q)) begin
        seq_err_d = 1'b1;
      end
      if (ex_q == X_LAST) begin
        ex_d = '0;
        ey_d = (ey_q == Y_LAST) ? '0 : ey_q + 9'd1;
      end else begin
        ex_d = ex_q + 10'd1;
      end
      if (bank_last) begin
        fill_bank_d        = !fill_bank_q;
        eof_d[fill_bank_q] = pix_last;
      end
    end
  end

  // Fill sets and drain clears always target different banks, so both apply.
  always_comb begin
    full_d = full_q;
    if (accept && bank_last) begin
      full_d[fill_bank_q] = 1'b1;
    end
    if (burst_done) begin
      full_d[drain_bank_q] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q           <= '0;
      ey_q           <= '0;
      fill_bank_q    <= 1'b0;
      full_q         <= '0;
      eof_q          <= '0;
      seq_err_q      <= 1'b0;
      bank_addr_q[0] <= '0;
      bank_addr_q[1] <= '0;
    end else begin
      ex_q        <= ex_d;
      ey_q        <= ey_d;
      fill_bank_q <= fill_bank_d;
      full_q      <= full_d;
      eof_q       <= eof_d;
      seq_err_q   <= seq_err_d;
      if (accept && bank_first) begin
        bank_addr_q[fill_bank_q] <= pix_addr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      if (ex_q[0]) begin
        mem_q[fill_bank_q][wsel][31:16] <= pix_data;
      end else begin
        mem_q[fill_bank_q][wsel][15:0] <= pix_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      beat_q       <= '0;
      drain_bank_q <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      drain_bank_q <= drain_bank_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    drain_bank_d = drain_bank_q;
    frame_done_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (full_q[drain_bank_q]) begin
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (wr_ack) begin
          state_d = S_DATA;
          beat_d  = '0;
        end
      end
      S_DATA: begin
        if (xfer) begin
          beat_d = beat_q + 1'b1;
          if (burst_done) begin
            state_d      = S_IDLE;
            drain_bank_d = !drain_bank_q;
            frame_done_d = eof_q[drain_bank_q];
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decode registered state only, so they hold steady across stalls.
  always_comb begin
    wr_req        = 1'b0;
    wr_addr       = '0;
    wr_data_valid = 1'b0;
    wr_data       = '0;
    case (state_q)
      S_REQ: begin
        wr_req  = 1'b1;
        wr_addr = bank_addr_q[drain_bank_q];
      end
      S_DATA: begin
        wr_data_valid = 1'b1;
        wr_data       = mem_q[drain_bank_q][beat_q];
      end
      default: ;
    endcase
  end

  assign frame_done = frame_done_q;
  assign seq_err    = seq_err_q;

endmodule

// File: tb/tb_frac_pixel_writer.sv
// Scoreboard bench: a pixel model pushes expected bursts, a write-port responder pops and compares.
module tb_frac_pixel_writer;

  localparam int          H    = 16;
  localparam int          V    = 2;
  localparam int          BL   = 4;
  localparam logic [21:0] BASE = 22'h000000;

  typedef struct packed {
    logic              eof;
    logic [3:0][31:0]  words;
    logic [21:0]       addr;
  } burst_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pix_valid = 1'b0;
  logic        pix_ready;
  logic [15:0] pix_data = '0;
  logic [9:0]  pix_x = '0;
  logic [8:0]  pix_y = '0;
  logic        wr_req;
  logic [21:0] wr_addr;
  logic        wr_ack = 1'b0;
  logic [31:0] wr_data;
  logic        wr_data_valid;
  logic        wr_data_ready = 1'b1;
  logic        frame_done;
  logic        seq_err;

  frac_pixel_writer #(
    .H_RES(H), .V_RES(V), .BURST_LEN(BL), .FB_BASE(BASE)
  ) dut (
    .clk(clk), .rst(rst),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
    .pix_x(pix_x), .pix_y(pix_y),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_ack(wr_ack),
    .wr_data(wr_data), .wr_data_valid(wr_data_valid), .wr_data_ready(wr_data_ready),
    .frame_done(frame_done), .seq_err(seq_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model of the fill side
  burst_t exp_q[$];
  burst_t m_b;
  int     m_ex = 0, m_ey = 0, acc_cnt = 0, first_stall = -1;

  task automatic model_reset();
    exp_q.delete();
    m_ex = 0; m_ey = 0; acc_cnt = 0;
  endtask

  task automatic model_accept(input logic [15:0] d);
    int pos;
    pos = m_ex % (2 * BL);
    if (pos == 0) begin
      m_b.addr  = 22'(int'(BASE) + m_ey * H + m_ex);
      m_b.words = '0;
      m_b.eof   = 1'b0;
    end
    if (pos % 2 == 1) m_b.words[pos / 2][31:16] = d;
    else              m_b.words[pos / 2][15:0]  = d;
    if (pos == 2 * BL - 1) begin
      m_b.eof = (m_ex == H - 1) && (m_ey == V - 1);
      exp_q.push_back(m_b);
    end
    if (m_ex == H - 1) begin
      m_ex = 0;
      m_ey = (m_ey == V - 1) ? 0 : m_ey + 1;
    end else begin
      m_ex++;
    end
    acc_cnt++;
  endtask

  // Write-port responder
  burst_t      cur;
  int          beat_idx = 0, wait_cnt = 0, fd_count = 0, ack_delay = 0;
  bit          rdy_toggle = 0, in_burst = 0, fd_expect = 0, fd_eof = 0, ack_pending = 0, stalled = 0;
  logic [31:0] held_data = '0;
  logic [21:0] req_addr_first = '0;

  always @(negedge clk) begin
    if (rst) begin
      in_burst = 0; beat_idx = 0; wait_cnt = 0; fd_expect = 0; ack_pending = 0;
      stalled = 0; fd_count = 0; wr_ack = 1'b0; wr_data_ready = 1'b1;
    end else begin
      if (fd_expect) begin
        check("frame_done", frame_done, fd_eof);
        fd_expect = 0;
        if (frame_done) fd_count++;
      end else if (frame_done) begin
        check("frame_done_spurious", frame_done, 1'b0);
        fd_count++;
      end
      if (ack_pending) begin
        check("valid_after_ack", wr_data_valid, 1'b1);
        ack_pending = 0;
      end
      wr_ack = 1'b0;
      if (wr_req) begin
        if (wait_cnt == 0) req_addr_first = wr_addr;
        else check("wr_addr_hold", wr_addr, req_addr_first);
        if (wait_cnt >= ack_delay) begin
          wr_ack = 1'b1; wait_cnt = 0; ack_pending = 1;
          if (exp_q.size() == 0) begin
            check("unexpected_burst", 1, 0);
          end else begin
            cur = exp_q.pop_front();
            check("wr_addr", wr_addr, cur.addr);
            in_burst = 1; beat_idx = 0;
          end
        end else begin
          wait_cnt++;
        end
      end
      if (stalled) check("wr_data_hold", wr_data, held_data);
      stalled = 0;
      wr_data_ready = rdy_toggle ? !wr_data_ready : 1'b1;
      if (wr_data_valid) begin
        if (wr_data_ready) begin
          if (in_burst) check("wr_data", wr_data, cur.words[beat_idx]);
          else          check("beat_outside_burst", 1, 0);
          beat_idx++;
          if (beat_idx == BL) begin
            in_burst = 0; fd_expect = 1; fd_eof = cur.eof;
          end
        end else begin
          stalled = 1; held_data = wr_data;
        end
      end
    end
  end

  task automatic send_pixels(input int n, input int bad_idx, input logic [15:0] base, input bit rnd);
    logic [15:0] d;
    bit          got;
    for (int i = 0; i < n; i++) begin
      d = rnd ? 16'($urandom) : base + 16'(i);
      pix_valid = 1'b1;
      pix_data  = d;
      pix_x     = (i == bad_idx) ? 10'd5 : 10'(m_ex);
      pix_y     = 9'(m_ey);
      got = 0;
      for (int w = 0; w < 500; w++) begin
        @(negedge clk);
        if (pix_ready) begin
          got = 1;
          break;
        end
        if (first_stall < 0) first_stall = acc_cnt;
      end
      if (!got) begin
        check("pix_accept_timeout", 0, 1);
        pix_valid = 1'b0;
        return;
      end
      @(posedge clk);
      model_accept(d);
      #1;
    end
    pix_valid = 1'b0;
  endtask

  task automatic reset_release();
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", pix_ready, 1'b1);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    pix_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    check("rst_pix_ready", pix_ready, 1'b0);
    check("rst_wr_req", wr_req, 1'b0);
    check("rst_wr_valid", wr_data_valid, 1'b0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_frame_done", frame_done, 1'b0);
    check("rst_seq_err", seq_err, 1'b0);
    reset_release();
  endtask

  task automatic drain();
    for (int w = 0; w < 400; w++) begin
      @(negedge clk); #1;
      if (exp_q.size() == 0 && !in_burst && !wr_req && !wr_data_valid && !fd_expect) break;
    end
    check("scoreboard_empty", exp_q.size(), 0);
    check("burst_open", in_burst, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Basic burst with request-latency check
    do_reset();
    send_pixels(8, -1, 16'h0000, 0);
    @(negedge clk);
    check("req_t1", wr_req, 1'b0);
    @(negedge clk);
    check("req_t2", wr_req, 1'b1);
    drain();

    // Line wrap: second-line burst lands at BASE + H
    do_reset();
    send_pixels(H + 8, -1, 16'h1000, 0);
    drain();
    check("wrap_seq_err", seq_err, 1'b0);

    // Back-pressure: late ack and toggling data ready
    do_reset();
    ack_delay = 20; rdy_toggle = 1; first_stall = -1;
    send_pixels(24, -1, 16'h2000, 1);
    check("stall_after", first_stall, 16);
    drain();
    ack_delay = 0; rdy_toggle = 0;

    // Ordering error on the third pixel; data still placed by expected position
    do_reset();
    send_pixels(2, -1, 16'h3000, 0);
    @(negedge clk);
    check("seq_err_before", seq_err, 1'b0);
    @(posedge clk); #1;
    send_pixels(6, 0, 16'h3002, 0);
    @(negedge clk);
    check("seq_err_set", seq_err, 1'b1);
    @(posedge clk); #1;
    send_pixels(8, -1, 16'h3100, 0);
    drain();
    check("seq_err_sticky", seq_err, 1'b1);

    // Whole frame plus restart at base
    do_reset();
    send_pixels(H * V + 8, -1, 16'h0, 1);
    drain();
    check("frame_done_count", fd_count, 1);

    // Reset in the middle of a burst
    do_reset();
    send_pixels(8, -1, 16'h4000, 0);
    for (int w = 0; w < 100; w++) begin
      @(negedge clk); #1;
      if (beat_idx >= 2) break;
    end
    check("midburst_reached", (beat_idx >= 2), 1'b1);
    @(posedge clk); #1 rst = 1'b1;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check("midrst_valid", wr_data_valid, 1'b0);
    check("midrst_req", wr_req, 1'b0);
    reset_release();
    send_pixels(8, -1, 16'h5000, 0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
